johnson_monitor: RTL and testbench

- Downstream consumer of the 4-bit Johnson counter on the same clk.
- Samples the counter code every cycle, decodes it to a 3-bit phase index and checks that each step is legal (hold or single advance).
- Counts completed rotations and latches a sticky fault on any illegal code or illegal step.
- Feeds the board LEDs/display and flags counter corruption (glitch, bad reset, stuck bit).

---
 rtl/johnson_pkg.sv | 45 ++++
 rtl/johnson_decode.sv | 27 ++
 rtl/johnson_monitor.sv | 116 +++++++++++
 tb/tb_johnson_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter monitor: legal code table,
// FSM state encodings and active-low 7-segment (gfedcba) digit patterns.
package johnson_pkg;

  localparam logic [3:0] JCODE_S0 = 4'b0000;
  localparam logic [3:0] JCODE_S1 = 4'b0001;
  localparam logic [3:0] JCODE_S2 = 4'b0011;
  localparam logic [3:0] JCODE_S3 = 4'b0111;
  localparam logic [3:0] JCODE_S4 = 4'b1111;
  localparam logic [3:0] JCODE_S5 = 4'b1110;
  localparam logic [3:0] JCODE_S6 = 4'b1100;
  localparam logic [3:0] JCODE_S7 = 4'b1000;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_D0 = 7'b1000000;
  localparam logic [6:0] SEG_D1 = 7'b1111001;
  localparam logic [6:0] SEG_D2 = 7'b0100100;
  localparam logic [6:0] SEG_D3 = 7'b0110000;
  localparam logic [6:0] SEG_D4 = 7'b0011001;
  localparam logic [6:0] SEG_D5 = 7'b0010010;
  localparam logic [6:0] SEG_D6 = 7'b0000010;
  localparam logic [6:0] SEG_D7 = 7'b1111000;
  localparam logic [6:0] SEG_E  = 7'b0000110;

  function automatic logic [6:0] seg_digit(input logic [2:0] i);
    logic [6:0] s;
    case (i)
      3'd0:    s = SEG_D0;
      3'd1:    s = SEG_D1;
      3'd2:    s = SEG_D2;
      3'd3:    s = SEG_D3;
      3'd4:    s = SEG_D4;
      3'd5:    s = SEG_D5;
      3'd6:    s = SEG_D6;
      default: s = SEG_D7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a 4-bit Johnson code to its phase index;
// legal is low for the 8 codes that a healthy counter never produces.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [3:0] jin,
  output logic       legal,
  output logic [2:0] idx
);

  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (jin)
      JCODE_S0: idx = 3'd0;
      JCODE_S1: idx = 3'd1;
      JCODE_S2: idx = 3'd2;
      JCODE_S3: idx = 3'd3;
      JCODE_S4: idx = 3'd4;
      JCODE_S5: idx = 3'd5;
      JCODE_S6: idx = 3'd6;
      JCODE_S7: idx = 3'd7;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_monitor.sv
// Checks every step of an upstream 4-bit Johnson counter, counts rotations and
// latches a sticky fault. Optional seg output under JOHNSON_MONITOR_SEVSEG_EN.
module johnson_monitor
  import johnson_pkg::*;
#(
  parameter int WRAP_W     = 8,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        jin,
  input  logic              en,
  input  logic              clr,
  output logic [2:0]        idx,
  output logic              legal,
  output logic              err,
  output logic [WRAP_W-1:0] wraps,
`ifdef JOHNSON_MONITOR_SEVSEG_EN
  output logic [6:0]        seg,
`endif
  output logic [1:0]        state
);

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              legal_q;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              dec_legal;
  logic [2:0]        dec_idx;
  logic [2:0]        succ;
  logic              step_ok;

  johnson_decode u_decode (
    .jin   (jin),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  // idx_q doubles as the previous-sample index the step check compares to.
  assign succ    = idx_q + 3'd1;
  assign step_ok = dec_legal &&
                   ((en && (dec_idx == succ)) ||
                    ((dec_idx == idx_q) && (!en || ALLOW_HOLD)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wraps_d = wraps_q;
    case (state_q)
      ST_SYNC: begin
        if (dec_legal) begin
          state_d = ST_TRACK;
          idx_d   = dec_idx;
        end
      end
      ST_TRACK: begin
        if (step_ok) begin
          idx_d = dec_idx;
          if ((idx_q == 3'd7) && (dec_idx == 3'd0))
            wraps_d = wraps_q + WRAP_W'(1);
        end else begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end
      end
      ST_FAULT: ;
      default: begin
        state_d = ST_SYNC;
        err_d   = 1'b1;
      end
    endcase
    // clr overrides everything this edge, including a concurrent violation.
    if (clr) begin
      state_d = ST_SYNC;
      err_d   = 1'b0;
      idx_d   = idx_q;
      wraps_d = wraps_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SYNC;
      idx_q   <= 3'd0;
      legal_q <= 1'b0;
      err_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      legal_q <= dec_legal;
      err_q   <= err_d;
      wraps_q <= wraps_d;
    end
  end

`ifdef JOHNSON_MONITOR_SEVSEG_EN
  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg_q <= SEG_D0;
    else      seg_q <= (state_d == ST_FAULT) ? SEG_E : seg_digit(idx_d);
  end

  assign seg = seg_q;
`endif

  assign idx   = idx_q;
  assign legal = legal_q;
  assign err   = err_q;
  assign wraps = wraps_q;
  assign state = state_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Bench for johnson_monitor: two instances (WRAP_W=8/hold allowed, WRAP_W=2/hold
// forbidden) fed the same stimulus and compared against a behavioural model.
module tb_johnson_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] jin;
  logic       en;
  logic       clr;

  logic [2:0] idx0, idx1;
  logic       legal0, legal1;
  logic       err0, err1;
  logic [7:0] wraps0;
  logic [1:0] wraps1;
  logic [1:0] st0, st1;
`ifdef JOHNSON_MONITOR_SEVSEG_EN
  logic [6:0] seg0, seg1;
`endif

  int n_total = 0;
  int n_bad   = 0;

  johnson_monitor #(.WRAP_W(8), .ALLOW_HOLD(1'b1)) u0 (
    .clk(clk), .rst(rst), .jin(jin), .en(en), .clr(clr),
    .idx(idx0), .legal(legal0), .err(err0), .wraps(wraps0),
`ifdef JOHNSON_MONITOR_SEVSEG_EN
    .seg(seg0),
`endif
    .state(st0)
  );

  johnson_monitor #(.WRAP_W(2), .ALLOW_HOLD(1'b0)) u1 (
    .clk(clk), .rst(rst), .jin(jin), .en(en), .clr(clr),
    .idx(idx1), .legal(legal1), .err(err1), .wraps(wraps1),
`ifdef JOHNSON_MONITOR_SEVSEG_EN
    .seg(seg1),
`endif
    .state(st1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: phase ring of 8 codes, step rules as plain arithmetic
  logic [3:0] codes   [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30,
                              7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] seg_e   = 7'h06;
  int hold_ok [2] = '{1, 0};
  int wmod    [2] = '{256, 4};
  int m_st    [2];   // 0 sync, 1 track, 2 fault
  int m_idx   [2];
  int m_err   [2];
  int m_wraps [2];
  int m_legal;

  function automatic int find_phase(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_err[k] = 0; m_wraps[k] = 0;
    end
    m_legal = 0;
  endtask

  task automatic m_step(input logic [3:0] j, input logic e, input logic c);
    int d;
    d = find_phase(j);
    m_legal = (d >= 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_st[k] = 0;
        m_err[k] = 0;
      end else if (m_st[k] == 0) begin
        if (d >= 0) begin
          m_st[k] = 1;
          m_idx[k] = d;
        end
      end else if (m_st[k] == 1) begin
        if (d >= 0 && ((e && d == (m_idx[k] + 1) % 8) ||
                       (d == m_idx[k] && (!e || hold_ok[k] != 0)))) begin
          if (m_idx[k] == 7 && d == 0) m_wraps[k] = (m_wraps[k] + 1) % wmod[k];
          m_idx[k] = d;
        end else begin
          m_st[k] = 2;
          m_err[k] = 1;
        end
      end
    end
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("u0_state", 32'(st0),    32'(m_st[0]));
    check("u0_idx",   32'(idx0),   32'(m_idx[0]));
    check("u0_legal", 32'(legal0), 32'(m_legal));
    check("u0_err",   32'(err0),   32'(m_err[0]));
    check("u0_wraps", 32'(wraps0), 32'(m_wraps[0]));
    check("u1_state", 32'(st1),    32'(m_st[1]));
    check("u1_idx",   32'(idx1),   32'(m_idx[1]));
    check("u1_legal", 32'(legal1), 32'(m_legal));
    check("u1_err",   32'(err1),   32'(m_err[1]));
    check("u1_wraps", 32'(wraps1), 32'(m_wraps[1]));
`ifdef JOHNSON_MONITOR_SEVSEG_EN
    check("u0_seg", 32'(seg0), 32'((m_st[0] == 2) ? seg_e : seg_tab[m_idx[0]]));
    check("u1_seg", 32'(seg1), 32'((m_st[1] == 2) ? seg_e : seg_tab[m_idx[1]]));
`endif
  endtask

  // driver tasks
  task automatic cycle(input logic [3:0] j, input logic e, input logic c);
    jin = j; en = e; clr = c;
    @(posedge clk);
    m_step(j, e, c);
    #1;
    check_all();
  endtask

  // asserts reset between edges and checks the asynchronous response
  task automatic mid_reset();
    #3;
    rst = 1'b0;
    #1;
    m_reset();
    check_all();
    check("rst_u0_state", 32'(st0), 32'd0);
    check("rst_u0_wraps", 32'(wraps0), 32'd0);
`ifdef JOHNSON_MONITOR_SEVSEG_EN
    check("rst_u0_seg", 32'(seg0), 32'h40);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int w;
    int r;
    rst = 1'b0; jin = 4'b0000; en = 1'b0; clr = 1'b0;
    m_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // full rotation 0..7,0
    for (int s = 0; s <= 8; s++) cycle(codes[s % 8], 1'b1, 1'b0);
    check("t1_state", 32'(st0), 32'd1);
    check("t1_wraps", 32'(wraps0), 32'd1);

    // bad code at idx 3, then clear
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0);
    cycle(4'b0111, 1'b1, 1'b0);
    cycle(4'b0101, 1'b1, 1'b0);
    check("t2_fault", 32'(st0), 32'd2);
    check("t2_idx", 32'(idx0), 32'd3);
    cycle(4'b0101, 1'b0, 1'b1);
    check("t2_clr_err", 32'(err0), 32'd0);
    check("t2_clr_wraps", 32'(wraps0), 32'd1);

    // holds on en cycles, then a move with en low
    for (int s = 0; s < 4; s++) cycle(4'b0011, 1'b1, 1'b0);
    check("t3_hold_u0", 32'(st0), 32'd1);
    check("t3_hold_u1", 32'(st1), 32'd2);
    cycle(4'b0111, 1'b0, 1'b0);
    check("t3_move_noen", 32'(st0), 32'd2);

    // illegal code while in sync
    mid_reset();
    for (int s = 0; s < 4; s++) cycle(4'b1010, 1'b1, 1'b0);
    check("t4_sync", 32'(st0), 32'd0);
    cycle(4'b1110, 1'b1, 1'b0);
    check("t4_idx", 32'(idx0), 32'd5);

    // five rotations on the 2-bit wrap counter
    mid_reset();
    cycle(4'b0000, 1'b1, 1'b0);
    for (int rot = 0; rot < 5; rot++) begin
      for (int s = 1; s <= 8; s++) cycle(codes[s % 8], 1'b1, 1'b0);
      check("t5_wraps", 32'(wraps1), 32'((rot + 1) % 4));
    end

    // reset while faulted
    cycle(4'b0011, 1'b1, 1'b0);
    mid_reset();

    // random walk: mostly legal steps with holds, jumps, glitches and clears
    w = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] j;
      logic e;
      logic c;
      r = $urandom_range(0, 99);
      e = 1'b1;
      if (r < 60) begin
        w = (w + 1) % 8;
        j = codes[w];
      end else if (r < 78) begin
        e = 1'($urandom_range(0, 1));
        j = codes[w];
      end else if (r < 88) begin
        e = 1'($urandom_range(0, 1));
        w = $urandom_range(0, 7);
        j = codes[w];
      end else begin
        e = 1'($urandom_range(0, 1));
        j = 4'($urandom_range(0, 15));
      end
      c = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      cycle(j, e, c);
      if (i % 1000 == 500) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
